// File: rtl/audio_pkg.sv
// Shared audio constants and the click player's state encoding.
package audio_pkg;

  localparam logic [7:0] ROM_SILENCE = 8'h80;
  localparam int         SAMPLE_W    = 16;
  localparam int         ACC_SHIFT   = 8;
  localparam int         NORM_SHIFT  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/metronome_player_if.sv
// Click-sample ROM bus: registered address out, data back one clock later.
interface metronome_player_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);
endinterface

// File: rtl/metronome_tempo.sv
// Beat timing: counts sample ticks per beat and beats per bar, flags the
// beat event combinationally in the tick cycle and strobes one cycle later.
module metronome_tempo
  import audio_pkg::*;
#(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] beat_period,
  input  logic [2:0]          beats_per_bar,
  input  logic                sample_tick,
  output logic                beat_evt,
  output logic                accent,
  output logic                beat_pulse,
  output logic                bar_pulse
);

  logic [PERIOD_W-1:0] tick_cnt;
  logic [2:0]          beat_num;
  logic [3:0]          beat_next;
  logic                running;

  assign running   = enable && (beat_period != '0);
  assign beat_evt  = running && sample_tick && (tick_cnt == '0);
  assign accent    = (beats_per_bar != 3'd0) && (beat_num == 3'd0);
  assign beat_next = {1'b0, beat_num} + 4'd1;

  // Comparing with >= lets a shortened period take effect at the next tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt   <= '0;
      beat_num   <= '0;
      beat_pulse <= 1'b0;
      bar_pulse  <= 1'b0;
    end else begin
      beat_pulse <= beat_evt;
      bar_pulse  <= beat_evt && accent;
      if (!running)
        tick_cnt <= '0;
      else if (sample_tick)
        tick_cnt <= (tick_cnt >= beat_period - 1'b1) ? '0 : tick_cnt + 1'b1;
      if (!enable)
        beat_num <= '0;
      else if (beat_evt)
        beat_num <= (beat_next >= {1'b0, beats_per_bar}) ? 3'd0 : beat_next[2:0];
    end
  end

endmodule

// File: rtl/metronome_player.sv
// Metronome click player: walks the click ROM once per beat and streams
// signed 16-bit samples, one per audio tick, louder on the bar's first beat.
module metronome_player
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int CLICK_LEN  = 16384,
  parameter int PERIOD_W   = 20
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic [PERIOD_W-1:0]        beat_period,
  input  logic [2:0]                 beats_per_bar,
  input  logic                       sample_tick,
  metronome_player_if.master         rom,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       beat_pulse,
  output logic                       bar_pulse,
  output logic                       playing
);

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] idx, addr;
  logic                  accent_q;
  logic                  beat_evt, accent;
  logic                  last_idx;
  logic [SAMPLE_W-1:0]   centered, shaped;

  metronome_tempo #(.PERIOD_W(PERIOD_W)) u_tempo (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .beat_period   (beat_period),
    .beats_per_bar (beats_per_bar),
    .sample_tick   (sample_tick),
    .beat_evt      (beat_evt),
    .accent        (accent),
    .beat_pulse    (beat_pulse),
    .bar_pulse     (bar_pulse)
  );

  assign rom.rom_addr = addr;
  assign last_idx     = (idx == ADDR_WIDTH'(CLICK_LEN - 1));

  // Zero-extend before centring so the modular subtract yields two's complement.
  assign centered = SAMPLE_W'(rom.rom_q) - SAMPLE_W'(ROM_SILENCE);
  assign shaped   = accent_q ? (centered << ACC_SHIFT) : (centered << NORM_SHIFT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, PLAY: if (sample_tick) next_state = CAPTURE;
        CAPTURE:    next_state = (beat_evt || (playing && !last_idx)) ? PLAY : IDLE;
        default:    next_state = IDLE;
      endcase
    end
  end

  // A beat is applied after the capture advance so it always restarts at 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx          <= '0;
      addr         <= '0;
      playing      <= 1'b0;
      accent_q     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else if (!enable) begin
      idx          <= '0;
      addr         <= '0;
      playing      <= 1'b0;
      accent_q     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (state == CAPTURE) begin
        sample_valid <= 1'b1;
        sample_out   <= playing ? shaped : '0;
        if (playing) begin
          if (last_idx) begin
            playing <= 1'b0;
            idx     <= '0;
            addr    <= '0;
          end else begin
            idx  <= idx + 1'b1;
            addr <= idx + 1'b1;
          end
        end
      end
      if (beat_evt) begin
        idx      <= '0;
        addr     <= '0;
        playing  <= 1'b1;
        accent_q <= accent;
      end
    end
  end

endmodule

// File: tb/tb_metronome_player.sv
// Directed bench: two players (click lengths 4 and 8) share one stimulus,
// each reading its own registered-read ROM model over a common memory image.
module tb_metronome_player;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] beat_period = '0;
  logic [2:0]  beats_per_bar = '0;
  logic        sample_tick = 1'b0;

  logic signed [15:0] sample_out_a, sample_out_b;
  logic sample_valid_a, sample_valid_b, beat_pulse_a, beat_pulse_b;
  logic bar_pulse_a, bar_pulse_b, playing_a, playing_b;

  logic [7:0] mem [0:16383];

  int checks = 0;
  int failures = 0;

  // Values sampled by applyStimulus: *_1 one clock after the tick, *_2 two clocks after.
  logic        beat_a1, bar_a1, play_a1, beat_b1, bar_b1, play_b1;
  logic [13:0] addr_a1, addr_b1;
  logic        valid_a2, valid_b2;
  logic [15:0] samp_a2, samp_b2;

  metronome_player_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) rom_a ();
  metronome_player_if #(.DATA_WIDTH(8), .ADDR_WIDTH(14)) rom_b ();

  metronome_player #(.DATA_WIDTH(8), .ADDR_WIDTH(14), .CLICK_LEN(4), .PERIOD_W(20)) dut_a (
    .clk(clk), .resetn(resetn), .enable(enable), .beat_period(beat_period),
    .beats_per_bar(beats_per_bar), .sample_tick(sample_tick), .rom(rom_a.master),
    .sample_out(sample_out_a), .sample_valid(sample_valid_a), .beat_pulse(beat_pulse_a),
    .bar_pulse(bar_pulse_a), .playing(playing_a)
  );

  metronome_player #(.DATA_WIDTH(8), .ADDR_WIDTH(14), .CLICK_LEN(8), .PERIOD_W(20)) dut_b (
    .clk(clk), .resetn(resetn), .enable(enable), .beat_period(beat_period),
    .beats_per_bar(beats_per_bar), .sample_tick(sample_tick), .rom(rom_b.master),
    .sample_out(sample_out_b), .sample_valid(sample_valid_b), .beat_pulse(beat_pulse_b),
    .bar_pulse(bar_pulse_b), .playing(playing_b)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    rom_a.rom_q <= mem[rom_a.rom_addr];
    rom_b.rom_q <= mem[rom_b.rom_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One tick, sampled in the capture cycle and in the sample_valid cycle.
  task automatic applyStimulus();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    beat_a1 = beat_pulse_a; bar_a1 = bar_pulse_a; play_a1 = playing_a; addr_a1 = rom_a.rom_addr;
    beat_b1 = beat_pulse_b; bar_b1 = bar_pulse_b; play_b1 = playing_b; addr_b1 = rom_b.rom_addr;
    @(posedge clk); #1;
    valid_a2 = sample_valid_a; samp_a2 = sample_out_a;
    valid_b2 = sample_valid_b; samp_b2 = sample_out_b;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic fillRom(input logic [7:0] v);
    for (int i = 0; i < 16384; i++) mem[i] = v;
  endtask

  initial begin
    fillRom(8'hFF);
    waitCycles(3);
    checkOutput("rst_addr", rom_a.rom_addr, 0);
    checkOutput("rst_sample", sample_out_a, 0);
    checkOutput("rst_valid", sample_valid_a, 0);
    checkOutput("rst_beat", beat_pulse_a, 0);
    checkOutput("rst_bar", bar_pulse_a, 0);
    checkOutput("rst_playing", playing_a, 0);
    resetn = 1'b1;
    waitCycles(2);

    $display("[TB] accent pattern, period 4, 2 beats per bar");
    beat_period = 20'd4; beats_per_bar = 3'd2; enable = 1'b1;
    applyStimulus();
    checkOutput("t1_beat", beat_a1, 1);
    checkOutput("t1_bar", bar_a1, 1);
    checkOutput("t1_valid", valid_a2, 1);
    checkOutput("t1_sample", samp_a2, 16'h7F00);
    for (int t = 2; t <= 4; t++) begin
      applyStimulus();
      checkOutput("t1_mid_beat", beat_a1, 0);
    end
    applyStimulus();
    checkOutput("t5_beat", beat_a1, 1);
    checkOutput("t5_bar", bar_a1, 0);
    checkOutput("t5_sample", samp_a2, 16'h3F80);
    for (int t = 6; t <= 8; t++) applyStimulus();
    applyStimulus();
    checkOutput("t9_bar", bar_a1, 1);
    checkOutput("t9_sample", samp_a2, 16'h7F00);
    enable = 1'b0;
    waitCycles(2);

    $display("[TB] full click of length 4, period 10");
    mem[0] = 8'h80; mem[1] = 8'h90; mem[2] = 8'h70; mem[3] = 8'h80;
    beat_period = 20'd10; beats_per_bar = 3'd2; enable = 1'b1;
    applyStimulus();
    checkOutput("c_addr0", addr_a1, 0);
    checkOutput("c_samp0", samp_a2, 16'h0000);
    checkOutput("c_play0", play_a1, 1);
    applyStimulus();
    checkOutput("c_addr1", addr_a1, 1);
    checkOutput("c_samp1", samp_a2, 16'h1000);
    applyStimulus();
    checkOutput("c_addr2", addr_a1, 2);
    checkOutput("c_samp2", samp_a2, 16'hF000);
    applyStimulus();
    checkOutput("c_addr3", addr_a1, 3);
    checkOutput("c_samp3", samp_a2, 16'h0000);
    applyStimulus();
    checkOutput("c_addr_wrap", addr_a1, 0);
    checkOutput("c_play_end", play_a1, 0);
    checkOutput("c_valid5", valid_a2, 1);
    checkOutput("c_samp5", samp_a2, 0);
    for (int t = 6; t <= 10; t++) begin
      applyStimulus();
      checkOutput("c_tail_samp", samp_a2, 0);
      checkOutput("c_tail_beat", beat_a1, 0);
    end
    enable = 1'b0;
    waitCycles(2);

    $display("[TB] retrigger, click length 8, period 3");
    fillRom(8'hFF);
    beat_period = 20'd3; beats_per_bar = 3'd0; enable = 1'b1;
    for (int t = 0; t < 7; t++) begin
      applyStimulus();
      checkOutput("r_addr", addr_b1, t % 3);
      checkOutput("r_play", play_b1, 1);
    end
    checkOutput("r_sample", samp_b2, 16'h3F80);
    checkOutput("r_nobar", bar_b1, 0);
    enable = 1'b0;
    waitCycles(2);

    $display("[TB] enable dropped mid-click");
    beat_period = 20'd10; beats_per_bar = 3'd3; enable = 1'b1;
    applyStimulus();
    checkOutput("e_samp_first", samp_b2, 16'h7F00);
    applyStimulus();
    applyStimulus();
    checkOutput("e_addr2", addr_b1, 2);
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    checkOutput("e_play_off", playing_b, 0);
    checkOutput("e_samp_off", sample_out_b, 0);
    checkOutput("e_valid_off", sample_valid_b, 0);
    for (int t = 0; t < 2; t++) begin
      applyStimulus();
      checkOutput("e_no_valid", valid_b2, 0);
    end
    enable = 1'b1;
    applyStimulus();
    checkOutput("e_re_beat", beat_b1, 1);
    checkOutput("e_re_bar", bar_b1, 1);
    checkOutput("e_re_addr", addr_b1, 0);
    checkOutput("e_re_samp", samp_b2, 16'h7F00);
    enable = 1'b0;
    waitCycles(2);

    $display("[TB] zero period streams silence");
    beat_period = 20'd0; beats_per_bar = 3'd2; enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      applyStimulus();
      checkOutput("z_beat", beat_a1, 0);
      checkOutput("z_valid", valid_a2, 1);
      checkOutput("z_samp", samp_a2, 0);
    end
    enable = 1'b0;
    waitCycles(2);

    $display("[TB] reset during capture");
    beat_period = 20'd4; beats_per_bar = 3'd2; enable = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    checkOutput("x_pre_play", playing_a, 1);
    checkOutput("x_pre_bar", bar_pulse_a, 1);
    resetn = 1'b0;
    #1;
    checkOutput("x_beat", beat_pulse_a, 0);
    checkOutput("x_bar", bar_pulse_a, 0);
    checkOutput("x_play", playing_a, 0);
    checkOutput("x_valid", sample_valid_a, 0);
    checkOutput("x_samp", sample_out_a, 0);
    checkOutput("x_addr", rom_a.rom_addr, 0);
    #2 resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("x_post_valid", sample_valid_a, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
